// File: rtl/pchk_pkg.sv
// Shared types for the pipeline checkpoint monitor: FSM states, slot record, default widths.
package pchk_pkg;

  localparam int DEF_NUM_CHECKS = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_CYCLE_W    = 32;
  localparam int DEF_REG_IDX_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SNAP,
    ST_CHECK,
    ST_DONE
  } pchk_state_e;

  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_IDX_W-1:0]  idx;
    logic [DEF_DATA_W-1:0]     expected;
  } pchk_slot_t;

endpackage

// File: rtl/pchk_slot_table.sv
// Expected-value slot table: synchronous write, synchronous clear on reset, combinational read.
module pchk_slot_table
  import pchk_pkg::*;
#(
  parameter int  NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int  SLOT_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  parameter type slot_t     = pchk_slot_t
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SLOT_W-1:0] wr_slot,
  input  slot_t             wr_data,
  input  logic [SLOT_W-1:0] rd_slot,
  output slot_t             rd_data
);

  localparam logic [SLOT_W:0] NUM_L = (SLOT_W+1)'(NUM_CHECKS);

  slot_t table_q [NUM_CHECKS];
  slot_t table_d [NUM_CHECKS];

  always_comb begin
    table_d = table_q;
    if (we && ({1'b0, wr_slot} < NUM_L)) table_d[wr_slot] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) table_q[i] <= '0;
    end else begin
      table_q <= table_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_slot} < NUM_L) rd_data = table_q[rd_slot];
  end

endmodule

// File: rtl/pipeline_checkpoint_monitor.sv
// Run-to-checkpoint monitor: count, freeze, snapshot PC/ALU, walk the expected-value table.
// Optional PCHK_MISMATCH_MASK_EN adds a per-slot mismatch_mask output.
module pipeline_checkpoint_monitor
  import pchk_pkg::*;
#(
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CYCLE_W    = DEF_CYCLE_W,
  parameter int REG_IDX_W  = DEF_REG_IDX_W,
  parameter int SLOT_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic                 cfg_valid,
  input  logic [REG_IDX_W-1:0] cfg_idx,
  input  logic [DATA_W-1:0]    cfg_expected,
  input  logic                 start,
  input  logic [CYCLE_W-1:0]   target_cycle,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]    alu_out_in,
  output logic [REG_IDX_W-1:0] dbg_rd_idx,
  input  logic [DATA_W-1:0]    dbg_rd_data,
  output logic                 freeze,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SLOT_W:0]      fail_count,
  output logic [SLOT_W-1:0]    first_fail_slot,
  output logic [DATA_W-1:0]    first_fail_value,
  output logic [DATA_W-1:0]    snap_pc,
  output logic [DATA_W-1:0]    snap_alu,
  output logic [CYCLE_W-1:0]   cycle_count
`ifdef PCHK_MISMATCH_MASK_EN
  ,
  output logic [NUM_CHECKS-1:0] mismatch_mask
`endif
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHECKS - 1);

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    expected;
  } slot_t;

  pchk_state_e          state_q, state_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [CYCLE_W-1:0]   target_q, target_d;
  logic [SLOT_W-1:0]    ptr_q, ptr_d;
  logic [SLOT_W:0]      fail_cnt_q, fail_cnt_d;
  logic [SLOT_W-1:0]    first_slot_q, first_slot_d;
  logic [DATA_W-1:0]    first_val_q, first_val_d;
  logic [DATA_W-1:0]    snap_pc_q, snap_pc_d;
  logic [DATA_W-1:0]    snap_alu_q, snap_alu_d;
  logic                 freeze_q, freeze_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
`ifdef PCHK_MISMATCH_MASK_EN
  logic [NUM_CHECKS-1:0] mask_q, mask_d;
`endif

  slot_t wr_slot_data;
  slot_t rd_slot;
  logic  table_we;
  logic  running;
  logic  slot_mismatch;

  assign running       = (state_q == ST_COUNT) || (state_q == ST_SNAP) || (state_q == ST_CHECK);
  assign table_we      = cfg_we && !running;
  assign wr_slot_data  = '{valid: cfg_valid, idx: cfg_idx, expected: cfg_expected};
  assign slot_mismatch = rd_slot.valid && (dbg_rd_data != rd_slot.expected);
  assign dbg_rd_idx    = (state_q == ST_CHECK) ? rd_slot.idx : '0;

  pchk_slot_table #(
    .NUM_CHECKS (NUM_CHECKS),
    .SLOT_W     (SLOT_W),
    .slot_t     (slot_t)
  ) u_slot_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (table_we),
    .wr_slot (cfg_slot),
    .wr_data (wr_slot_data),
    .rd_slot (ptr_q),
    .rd_data (rd_slot)
  );

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    target_d     = target_q;
    ptr_d        = ptr_q;
    fail_cnt_d   = fail_cnt_q;
    first_slot_d = first_slot_q;
    first_val_d  = first_val_q;
    snap_pc_d    = snap_pc_q;
    snap_alu_d   = snap_alu_q;
    pass_d       = pass_q;
`ifdef PCHK_MISMATCH_MASK_EN
    mask_d       = mask_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_COUNT;
          cycle_d      = CYCLE_W'(1);
          target_d     = (target_cycle == '0) ? CYCLE_W'(1) : target_cycle;
          fail_cnt_d   = '0;
          first_slot_d = '0;
          first_val_d  = '0;
          pass_d       = 1'b0;
`ifdef PCHK_MISMATCH_MASK_EN
          mask_d       = '0;
`endif
        end
      end
      ST_COUNT: begin
        // Counter holds at the target, so it can never wrap even for an all-ones target.
        if (cycle_q == target_q) state_d = ST_SNAP;
        else                     cycle_d = cycle_q + 1'b1;
      end
      ST_SNAP: begin
        snap_pc_d  = pc_in;
        snap_alu_d = alu_out_in;
        ptr_d      = '0;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (slot_mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) begin
            first_slot_d = ptr_q;
            first_val_d  = dbg_rd_data;
          end
`ifdef PCHK_MISMATCH_MASK_EN
          mask_d[ptr_q] = 1'b1;
`endif
        end
        if (ptr_q == LAST_SLOT) begin
          state_d = ST_DONE;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_COUNT) || (state_d == ST_SNAP) || (state_d == ST_CHECK);
    freeze_d = (state_d == ST_SNAP) || (state_d == ST_CHECK) || (state_d == ST_DONE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cycle_q      <= '0;
      target_q     <= '0;
      ptr_q        <= '0;
      fail_cnt_q   <= '0;
      first_slot_q <= '0;
      first_val_q  <= '0;
      snap_pc_q    <= '0;
      snap_alu_q   <= '0;
      freeze_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
`ifdef PCHK_MISMATCH_MASK_EN
      mask_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      target_q     <= target_d;
      ptr_q        <= ptr_d;
      fail_cnt_q   <= fail_cnt_d;
      first_slot_q <= first_slot_d;
      first_val_q  <= first_val_d;
      snap_pc_q    <= snap_pc_d;
      snap_alu_q   <= snap_alu_d;
      freeze_q     <= freeze_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
`ifdef PCHK_MISMATCH_MASK_EN
      mask_q       <= mask_d;
`endif
    end
  end

  assign freeze           = freeze_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_cnt_q;
  assign first_fail_slot  = first_slot_q;
  assign first_fail_value = first_val_q;
  assign snap_pc          = snap_pc_q;
  assign snap_alu         = snap_alu_q;
  assign cycle_count      = cycle_q;
`ifdef PCHK_MISMATCH_MASK_EN
  assign mismatch_mask    = mask_q;
`endif

endmodule

// File: tb/tb_pipeline_checkpoint_monitor.sv
// Bench for pipeline_checkpoint_monitor: timeline-based reference model plus directed and random runs.
module tb_pipeline_checkpoint_monitor;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_slot = '0;
  logic        cfg_valid = 1'b0;
  logic [4:0]  cfg_idx = '0;
  logic [31:0] cfg_expected = '0;
  logic        start = 1'b0;
  logic [31:0] target_cycle = '0;
  logic [31:0] pc_in, alu_out_in;
  logic [4:0]  dbg_rd_idx;
  logic [31:0] dbg_rd_data;
  logic        freeze, busy, done, pass;
  logic [3:0]  fail_count;
  logic [2:0]  first_fail_slot;
  logic [31:0] first_fail_value, snap_pc, snap_alu, cycle_count;
`ifdef PCHK_MISMATCH_MASK_EN
  logic [7:0]  mismatch_mask;
`endif

  logic [31:0] regs [32];
  logic [31:0] gcnt = '0;

  int checks = 0;
  int errors = 0;

  pipeline_checkpoint_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_valid(cfg_valid),
    .cfg_idx(cfg_idx), .cfg_expected(cfg_expected),
    .start(start), .target_cycle(target_cycle),
    .pc_in(pc_in), .alu_out_in(alu_out_in),
    .dbg_rd_idx(dbg_rd_idx), .dbg_rd_data(dbg_rd_data),
    .freeze(freeze), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_slot(first_fail_slot),
    .first_fail_value(first_fail_value),
    .snap_pc(snap_pc), .snap_alu(snap_alu), .cycle_count(cycle_count)
`ifdef PCHK_MISMATCH_MASK_EN
    , .mismatch_mask(mismatch_mask)
`endif
  );

  always #5 clk = ~clk;

  // Processor stand-in: PC and ALU values are pure functions of the global edge count.
  function automatic logic [31:0] f_pc(input logic [31:0] g);
    return 32'h0040_0000 + (g << 2);
  endfunction
  function automatic logic [31:0] f_alu(input logic [31:0] g);
    return (g * 32'h9E37_79B9) ^ 32'h0000_5A5A;
  endfunction

  always @(posedge clk) gcnt <= gcnt + 1;
  assign pc_in       = f_pc(gcnt);
  assign alu_out_in  = f_alu(gcnt);
  assign dbg_rd_data = regs[dbg_rd_idx];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline of edges e since the start edge (e=0 is the start edge).
  // Frozen from e>=T, checking slot e-T-1 for e in T+1..T+N, done from e>=T+N+1.
  bit          m_init = 0;
  bit          m_running = 0;
  int          m_e = 0;
  int          m_T = 1;
  bit          m_valid [N];
  logic [4:0]  m_idx [N];
  logic [31:0] m_exp [N];
  bit          m_pass;
  int          m_fcnt;
  int          m_fslot;
  logic [31:0] m_fval, m_snap_pc, m_snap_alu, m_next_pc, m_next_alu;
  logic [7:0]  m_mask;

  function automatic bit m_busy();
    return m_running && (m_e <= m_T + N);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; m_running = 0; m_e = 0;
      for (int s = 0; s < N; s++) begin m_valid[s] = 0; m_idx[s] = '0; m_exp[s] = '0; end
      m_pass = 0; m_fcnt = 0; m_fslot = 0; m_fval = '0; m_mask = '0;
      m_snap_pc = '0; m_snap_alu = '0;
    end else begin
      bit b;
      b = m_busy();
      if (cfg_we && !b) begin
        m_valid[cfg_slot] = cfg_valid; m_idx[cfg_slot] = cfg_idx; m_exp[cfg_slot] = cfg_expected;
      end
      if (start && !b) begin
        m_running = 1; m_e = 0;
        m_T = (target_cycle == 0) ? 1 : int'(target_cycle);
        m_next_pc  = f_pc(gcnt + 32'(1 + m_T));
        m_next_alu = f_alu(gcnt + 32'(1 + m_T));
        m_pass = 0; m_fcnt = 0; m_fslot = 0; m_fval = '0; m_mask = '0;
      end else if (b) begin
        m_e++;
        if (m_e == m_T + N + 1) begin
          m_snap_pc = m_next_pc; m_snap_alu = m_next_alu;
          for (int s = 0; s < N; s++) begin
            if (m_valid[s] && regs[m_idx[s]] != m_exp[s]) begin
              if (m_fcnt == 0) begin m_fslot = s; m_fval = regs[m_idx[s]]; end
              m_fcnt++;
              m_mask[s] = 1'b1;
            end
          end
          m_pass = (m_fcnt == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      int cc;
      bit exp_done;
      cc = !m_running ? 0 : ((m_e + 1 < m_T) ? m_e + 1 : m_T);
      exp_done = m_running && (m_e >= m_T + N + 1);
      chk("busy", busy, m_busy());
      chk("done", done, exp_done);
      chk("freeze", freeze, m_running && (m_e >= m_T));
      chk("cycle_count", cycle_count, cc);
      if (m_running && m_e >= m_T + 1 && m_e <= m_T + N)
        chk("dbg_rd_idx", dbg_rd_idx, m_idx[m_e - m_T - 1]);
      if (!m_running) chk("dbg_rd_idx_idle", dbg_rd_idx, 0);
      if (exp_done || !m_running) begin
        chk("pass", pass, m_pass);
        chk("fail_count", fail_count, m_fcnt);
        chk("first_fail_slot", first_fail_slot, m_fslot);
        chk("first_fail_value", first_fail_value, m_fval);
        chk("snap_pc", snap_pc, m_snap_pc);
        chk("snap_alu", snap_alu, m_snap_alu);
`ifdef PCHK_MISMATCH_MASK_EN
        chk("mismatch_mask", mismatch_mask, m_mask);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int slot, input bit v, input int idx, input logic [31:0] e);
    cfg_we = 1; cfg_slot = 3'(slot); cfg_valid = v; cfg_idx = 5'(idx); cfg_expected = e;
    tick();
    cfg_we = 0;
  endtask

  task automatic kick(input int tgt);
    start = 1; target_cycle = tgt;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int lat0, input bit noise, output int lat);
    lat = lat0;
    while (lat < 4000) begin
      tick();
      lat++;
      if (done) break;
      if (noise) begin
        start = ($urandom % 5 == 0);
        target_cycle = $urandom % 4;
        cfg_we = ($urandom % 4 == 0);
        cfg_slot = 3'($urandom % 8);
        cfg_valid = 1;
        cfg_idx = 5'($urandom % 32);
        cfg_expected = $urandom;
      end
    end
    start = 0; cfg_we = 0;
    chk("run_timeout", done, 1);
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    int lat;
    logic [31:0] obs_pc, obs_alu;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[19] = 0; regs[20] = 10; regs[21] = 15;

    tick(); tick();
    rst_n = 1;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_freeze", freeze, 0);
    chk("reset_done", done, 0);

    // Basic passing run, target 13.
    cfg_write(0, 1, 19, 0);
    cfg_write(1, 1, 20, 10);
    cfg_write(2, 1, 21, 15);
    kick(13);
    repeat (13) tick();
    obs_pc = pc_in; obs_alu = alu_out_in;
    chk("t1_freeze_at_snap", freeze, 1);
    chk("t1_cycle_at_snap", cycle_count, 13);
    wait_done(13, 0, lat);
    chk("t1_latency", lat, 22);
    chk("t1_pass", pass, 1);
    chk("t1_fail_count", fail_count, 0);
    chk("t1_snap_pc", snap_pc, obs_pc);
    chk("t1_snap_alu", snap_alu, obs_alu);

    // One mismatching register, rerun from DONE with the table retained.
    regs[20] = 11;
    kick(13);
    wait_done(0, 0, lat);
    chk("t2_pass", pass, 0);
    chk("t2_fail_count", fail_count, 1);
    chk("t2_first_slot", first_fail_slot, 1);
    chk("t2_first_value", first_fail_value, 11);
`ifdef PCHK_MISMATCH_MASK_EN
    chk("t2_mask", mismatch_mask, 8'b0000_0010);
`endif

    // Target 0 behaves like target 1.
    regs[20] = 10;
    for (int t = 0; t < 2; t++) begin
      kick(t);
      tick();
      chk("t3_freeze_at_snap", freeze, 1);
      chk("t3_cycle_at_snap", cycle_count, 1);
      wait_done(1, 0, lat);
      chk("t3_latency", lat, 10);
      chk("t3_pass", pass, 1);
    end

    // start and cfg_we during COUNT are ignored.
    regs[20] = 11;
    kick(10);
    tick(); tick();
    start = 1; target_cycle = 2;
    cfg_we = 1; cfg_slot = 1; cfg_valid = 1; cfg_idx = 20; cfg_expected = 11;
    tick();
    start = 0; cfg_we = 0;
    wait_done(3, 0, lat);
    chk("t4_latency", lat, 19);
    chk("t4_fail_count", fail_count, 1);
    chk("t4_first_slot", first_fail_slot, 1);

    // Reset while checking slot 3.
    kick(4);
    repeat (8) tick();
    chk("t5_busy_in_check", busy, 1);
    rst_n = 0;
    tick();
    chk("t5_rst_freeze", freeze, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cycle", cycle_count, 0);
    chk("t5_rst_snap_pc", snap_pc, 0);
    rst_n = 1;
    kick(3);
    wait_done(0, 0, lat);
    chk("t5_cleared_pass", pass, 1);
    chk("t5_cleared_latency", lat, 12);

    // All slots invalid, target 5.
    kick(5);
    wait_done(0, 0, lat);
    chk("t6_latency", lat, 14);
    chk("t6_pass", pass, 1);
    chk("t6_fail_count", fail_count, 0);

    // Random runs with noise on start/cfg while busy.
    for (int it = 0; it < 40; it++) begin
      int tgt;
      if ($urandom % 10 == 0) reset_pulse();
      for (int k = 0; k < 4; k++) regs[1 + $urandom % 31] = $urandom % 4;
      repeat ($urandom % 5) begin
        int idx;
        idx = $urandom % 32;
        cfg_write($urandom % 8, ($urandom % 4 != 0), idx,
                  ($urandom % 3 == 0) ? ($urandom % 4) : regs[idx]);
      end
      tgt = $urandom % 20;
      kick(tgt);
      wait_done(0, ($urandom % 2 == 1), lat);
      chk("rand_latency", lat, ((tgt == 0) ? 1 : tgt) + N + 1);
      repeat ($urandom % 3) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
